// File: rtl/lru_ctrl_lv1.sv
// -----------------------------------------------------------------------------
// lru_ctrl_lv1
//   Registered tree pseudo-LRU controller for one L1 cache. Each set holds a
//   3-bit PLRU word for a 4-way set. The block serves three requesters:
//     - hit/fill touch      : marks a way most-recently-used
//     - snoop-invalidate    : aims the tree at the invalidated way so that it
//                             becomes the next victim
//     - miss victim lookup  : returns the way to replace
//   The block also runs the init sweep after reset and the flush sweep. Each
//   sweep writes 3'b000 to every set, one set per cycle.
//
// Ports
//   clk          in   clock; all state changes on the rising edge
//   rst_n        in   asynchronous active-low reset
//   flush_req    in   1-cycle pulse: restart the init sweep
//   init_done    out  1 = sweep complete, requests are serviced
//   touch_req    in   touch request (highest write priority)
//   touch_index  in   set index of the touch
//   touch_way    in   way touched
//   inv_req      in   invalidate hint request
//   inv_index    in   set index of the invalidate
//   inv_way      in   way invalidated
//   inv_ack      out  same-cycle: the invalidate update is written this cycle
//   vic_req      in   victim lookup request, held until vic_ack
//   vic_index    in   set index to look up
//   vic_ack      out  1-cycle pulse in the cycle after acceptance
//   vic_way      out  victim way, valid while vic_ack = 1
// -----------------------------------------------------------------------------

`ifndef ASSOC_WID_LV1
`define ASSOC_WID_LV1 2
`endif
`ifndef INDEX_MSB_LV1
`define INDEX_MSB_LV1 11
`endif
`ifndef INDEX_LSB_LV1
`define INDEX_LSB_LV1 6
`endif
`ifndef LRU_VAR_WID_LV1
`define LRU_VAR_WID_LV1 3
`endif
`ifndef NUM_OF_SETS_LV1
`define NUM_OF_SETS_LV1 64
`endif

module lru_ctrl_lv1 #(
   parameter int ASSOC_WID   = `ASSOC_WID_LV1,
   parameter int INDEX_MSB   = `INDEX_MSB_LV1,
   parameter int INDEX_LSB   = `INDEX_LSB_LV1,
   parameter int LRU_VAR_WID = `LRU_VAR_WID_LV1,
   parameter int NUM_OF_SETS = `NUM_OF_SETS_LV1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush_req,
   output logic                         init_done,
   input  logic                         touch_req,
   input  logic [INDEX_MSB-INDEX_LSB:0] touch_index,
   input  logic [ASSOC_WID-1:0]         touch_way,
   input  logic                         inv_req,
   input  logic [INDEX_MSB-INDEX_LSB:0] inv_index,
   input  logic [ASSOC_WID-1:0]         inv_way,
   output logic                         inv_ack,
   input  logic                         vic_req,
   input  logic [INDEX_MSB-INDEX_LSB:0] vic_index,
   output logic                         vic_ack,
   output logic [ASSOC_WID-1:0]         vic_way
);

   localparam int IDX_W = INDEX_MSB - INDEX_LSB + 1;
   localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_OF_SETS - 1);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // PLRU helpers. Word layout p[2:0]:
   //   p[2] selects the half that holds the victim (0 = ways 0/1, 1 = ways 2/3)
   //   p[1] selects the victim inside ways 0/1
   //   p[0] selects the victim inside ways 2/3
   // ---------------------------------------------------------------------------

   // Victim way currently pointed to by a PLRU word.
   function automatic logic [ASSOC_WID-1:0] plru_victim(input logic [LRU_VAR_WID-1:0] word);
      logic [ASSOC_WID-1:0] way;
      case (word[2])
         1'b0:    way = {1'b0, word[1]};
         1'b1:    way = {1'b1, word[0]};
         default: way = {ASSOC_WID{1'b0}};
      endcase
      return way;
   endfunction

   // Touch: point every node on the path away from the touched way.
   function automatic logic [LRU_VAR_WID-1:0] plru_touch(input logic [LRU_VAR_WID-1:0] word,
                                                        input logic [ASSOC_WID-1:0]   way);
      logic [LRU_VAR_WID-1:0] upd;
      upd = word;
      case (way)
         2'd0:    upd[2:1] = 2'b11;
         2'd1:    upd[2:1] = 2'b10;
         2'd2:    begin upd[2] = 1'b0; upd[0] = 1'b1; end
         2'd3:    begin upd[2] = 1'b0; upd[0] = 1'b0; end
         default: upd = word;
      endcase
      return upd;
   endfunction

   // Invalidate hint: point every node on the path toward the freed way.
   function automatic logic [LRU_VAR_WID-1:0] plru_aim(input logic [LRU_VAR_WID-1:0] word,
                                                      input logic [ASSOC_WID-1:0]   way);
      logic [LRU_VAR_WID-1:0] upd;
      upd = word;
      case (way)
         2'd0:    upd[2:1] = 2'b00;
         2'd1:    upd[2:1] = 2'b01;
         2'd2:    begin upd[2] = 1'b1; upd[0] = 1'b0; end
         2'd3:    begin upd[2] = 1'b1; upd[0] = 1'b1; end
         default: upd = word;
      endcase
      return upd;
   endfunction

   // ---------------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------------
   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [IDX_W-1:0]       ctr_r;
   logic [IDX_W-1:0]       ctr_nxt_s;
   logic                   init_done_r;
   logic                   init_done_nxt_s;

   logic [LRU_VAR_WID-1:0] plru_mem_r [NUM_OF_SETS];

   logic                   wr_en_s;
   logic [IDX_W-1:0]       wr_idx_s;
   logic [LRU_VAR_WID-1:0] wr_data_s;

   logic                   vic_accept_s;
   logic [LRU_VAR_WID-1:0] vic_word_s;
   logic                   vic_ack_r;
   logic [ASSOC_WID-1:0]   vic_way_r;
   logic                   inv_ack_s;

   // Sweep FSM next state: flush always restarts the sweep from set 0.
   always_comb begin
      state_nxt_s     = state_r;
      ctr_nxt_s       = ctr_r;
      init_done_nxt_s = init_done_r;
      case (state_r)
         ST_INIT: begin
            if (flush_req) begin
               ctr_nxt_s = {IDX_W{1'b0}};
            end else if (ctr_r == LAST_SET) begin
               state_nxt_s     = ST_RUN;
               ctr_nxt_s       = {IDX_W{1'b0}};
               init_done_nxt_s = 1'b1;
            end else begin
               ctr_nxt_s = ctr_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
         end
         ST_RUN: begin
            if (flush_req) begin
               state_nxt_s     = ST_INIT;
               ctr_nxt_s       = {IDX_W{1'b0}};
               init_done_nxt_s = 1'b0;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         default: begin
            state_nxt_s     = ST_INIT;
            ctr_nxt_s       = {IDX_W{1'b0}};
            init_done_nxt_s = 1'b0;
         end
      endcase
   end

   // Sweep FSM state, sweep counter and init_done flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_INIT;
         ctr_r       <= {IDX_W{1'b0}};
         init_done_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         ctr_r       <= ctr_nxt_s;
         init_done_r <= init_done_nxt_s;
      end
   end

   // Single write port arbitration: sweep, else touch, else invalidate.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_idx_s  = {IDX_W{1'b0}};
      wr_data_s = {LRU_VAR_WID{1'b0}};
      if (state_r == ST_INIT) begin
         wr_en_s   = 1'b1;
         wr_idx_s  = ctr_r;
         wr_data_s = {LRU_VAR_WID{1'b0}};
      end else if (init_done_r && touch_req) begin
         wr_en_s   = 1'b1;
         wr_idx_s  = touch_index;
         wr_data_s = plru_touch(plru_mem_r[touch_index], touch_way);
      end else if (init_done_r && inv_req) begin
         wr_en_s   = 1'b1;
         wr_idx_s  = inv_index;
         wr_data_s = plru_aim(plru_mem_r[inv_index], inv_way);
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // An invalidate only lands when the touch port is idle; it is not queued.
   always_comb begin
      inv_ack_s = inv_req & init_done_r & ~touch_req;
   end

   // Victim lookup sees the word as it will stand after this cycle's write,
   // so a same-cycle touch/invalidate to the same set is forwarded.
   always_comb begin
      vic_accept_s = vic_req & init_done_r & ~vic_ack_r;
      if (wr_en_s && (wr_idx_s == vic_index)) begin
         vic_word_s = wr_data_s;
      end else begin
         vic_word_s = plru_mem_r[vic_index];
      end
   end

   // PLRU storage: clocked writes only, contents defined by the sweep.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         plru_mem_r[wr_idx_s] <= wr_data_s;
      end
   end

   // Victim response registers; vic_ack masks re-acceptance for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vic_ack_r <= 1'b0;
         vic_way_r <= {ASSOC_WID{1'b0}};
      end else begin
         vic_ack_r <= vic_accept_s;
         if (vic_accept_s) begin
            vic_way_r <= plru_victim(vic_word_s);
         end
      end
   end

   assign init_done = init_done_r;
   assign inv_ack   = inv_ack_s;
   assign vic_ack   = vic_ack_r;
   assign vic_way   = vic_way_r;

endmodule

// File: tb/tb_lru_ctrl_lv1.sv
// -----------------------------------------------------------------------------
// tb_lru_ctrl_lv1
//   Self-checking bench for lru_ctrl_lv1. A cycle-level reference model of
//   the PLRU words and sweep tracks every step. Expected victim ways are
//   pushed when a lookup is driven and popped when vic_ack is seen.
// -----------------------------------------------------------------------------
module tb_lru_ctrl_lv1;

   localparam int NSETS = 64;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush_req;
   logic       init_done;
   logic       touch_req;
   logic [5:0] touch_index;
   logic [1:0] touch_way;
   logic       inv_req;
   logic [5:0] inv_index;
   logic [1:0] inv_way;
   logic       inv_ack;
   logic       vic_req;
   logic [5:0] vic_index;
   logic       vic_ack;
   logic [1:0] vic_way;

   always #5 clk = ~clk;

   lru_ctrl_lv1 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_req   (flush_req),
      .init_done   (init_done),
      .touch_req   (touch_req),
      .touch_index (touch_index),
      .touch_way   (touch_way),
      .inv_req     (inv_req),
      .inv_index   (inv_index),
      .inv_way     (inv_way),
      .inv_ack     (inv_ack),
      .vic_req     (vic_req),
      .vic_index   (vic_index),
      .vic_ack     (vic_ack),
      .vic_way     (vic_way)
   );

   int         n_tests = 0;
   int         n_fail  = 0;

   logic [2:0] model [NSETS];
   bit         m_init;
   int         m_cnt;
   bit         m_ack;
   logic [1:0] exp_q [$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [2:0] m_touch(input logic [2:0] w, input logic [1:0] way);
      logic [2:0] r;
      r = w;
      if (way[1] == 1'b0) begin
         r[2] = 1'b1;
         r[1] = ~way[0];
      end else begin
         r[2] = 1'b0;
         r[0] = ~way[0];
      end
      return r;
   endfunction

   function automatic logic [2:0] m_inv(input logic [2:0] w, input logic [1:0] way);
      logic [2:0] r;
      r = w;
      if (way[1] == 1'b0) begin
         r[2] = 1'b0;
         r[1] = way[0];
      end else begin
         r[2] = 1'b1;
         r[0] = way[0];
      end
      return r;
   endfunction

   function automatic logic [1:0] m_victim(input logic [2:0] w);
      case (w)
         3'b000, 3'b001: return 2'd0;
         3'b010, 3'b011: return 2'd1;
         3'b100, 3'b110: return 2'd2;
         default:        return 2'd3;
      endcase
   endfunction

   // One clock cycle: drive, check combinational ack, advance model, check outputs.
   task automatic step(input bit t, input int ti, input int tw,
                       input bit iv, input int ii, input int iw,
                       input bit v, input int vi, input bit fl);
      bit acc;
      bit cur_init;
      logic [1:0] tw2;
      logic [1:0] iw2;
      tw2 = tw[1:0];
      iw2 = iw[1:0];
      touch_req = t;  touch_index = ti[5:0]; touch_way = tw2;
      inv_req   = iv; inv_index   = ii[5:0]; inv_way   = iw2;
      vic_req   = v;  vic_index   = vi[5:0];
      flush_req = fl;
      #1;
      cur_init = m_init;
      check_val("inv_ack", {31'd0, inv_ack}, {31'd0, iv & cur_init & ~t});
      acc = v && cur_init && !m_ack;
      if (!cur_init) begin
         model[m_cnt] = 3'b000;
         if (m_cnt == NSETS - 1) begin
            m_init = 1'b1;
            m_cnt  = 0;
         end else begin
            m_cnt++;
         end
      end else if (t) begin
         model[ti] = m_touch(model[ti], tw2);
      end else if (iv) begin
         model[ii] = m_inv(model[ii], iw2);
      end
      if (acc) exp_q.push_back(m_victim(model[vi]));
      if (fl) begin
         m_init = 1'b0;
         m_cnt  = 0;
      end
      m_ack = acc;
      @(posedge clk);
      #1;
      check_val("init_done", {31'd0, init_done}, {31'd0, m_init});
      check_val("vic_ack", {31'd0, vic_ack}, {31'd0, m_ack});
      if (vic_ack) begin
         if (exp_q.size() == 0) check_val("vic_unexpected", 32'd1, 32'd0);
         else check_val("vic_way", {30'd0, vic_way}, {30'd0, exp_q.pop_front()});
      end
      touch_req = 1'b0; inv_req = 1'b0; vic_req = 1'b0; flush_req = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic vic(input int idx);
      step(0, 0, 0, 0, 0, 0, 1, idx, 0);
   endtask

   task automatic touch(input int idx, input int way);
      step(1, idx, way, 0, 0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset in the middle of a cycle, held across one edge.
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check_val("rst_vic_ack", {31'd0, vic_ack}, 32'd0);
      check_val("rst_init_done", {31'd0, init_done}, 32'd0);
      m_init = 1'b0;
      m_cnt  = 0;
      m_ack  = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      check_val("rst_vic_way", {30'd0, vic_way}, 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      flush_req = 1'b0; touch_req = 1'b0; inv_req = 1'b0; vic_req = 1'b0;
      touch_index = 6'd0; touch_way = 2'd0;
      inv_index = 6'd0; inv_way = 2'd0; vic_index = 6'd0;
      m_init = 1'b0; m_cnt = 0; m_ack = 1'b0;
      for (int s = 0; s < NSETS; s++) model[s] = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_init_done", {31'd0, init_done}, 32'd0);
      check_val("reset_vic_ack", {31'd0, vic_ack}, 32'd0);
      check_val("reset_vic_way", {30'd0, vic_way}, 32'd0);
      rst_n = 1'b1;

      // 1: init sweep, requests ignored while it runs, then first lookup.
      idle(10);
      step(1, 5, 0, 1, 5, 1, 1, 5, 0);
      idle(53);
      vic(5);
      idle(1);

      // 2: touch all four ways, then re-touch way 0.
      touch(5, 0); touch(5, 1); touch(5, 2); touch(5, 3);
      vic(5);
      touch(5, 0);
      vic(5);
      idle(1);

      // 3: same-cycle touch and lookup on one set is forwarded.
      step(1, 9, 0, 0, 0, 0, 1, 9, 0);
      idle(1);

      // 4: touch beats invalidate; blocked invalidate retried next cycle.
      step(1, 3, 2, 1, 3, 0, 0, 0, 0);
      step(0, 0, 0, 1, 3, 1, 0, 0, 0);
      vic(3);
      idle(1);

      // Independent sets in one cycle, then held vic_req (2-cycle spacing).
      step(1, 20, 0, 0, 0, 0, 1, 21, 0);
      step(0, 0, 0, 1, 22, 3, 0, 0, 0);
      vic(20); vic(20); vic(20); vic(20);
      idle(1);
      vic(22);

      // 5: flush after touches; lookup in flight during the flush cycle.
      touch(7, 2);
      vic(7);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(30);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(63);
      vic(5); idle(1); vic(9); idle(1); vic(7); idle(1); vic(20);
      idle(1);

      // 6: reset during a victim acknowledge, then during a sweep.
      touch(11, 1);
      vic(11);
      async_reset();
      idle(20);
      async_reset();
      idle(64);
      touch(12, 3);
      vic(12);
      idle(2);

      check_val("queue_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
